// File: rtl/lamp_seq_monitor.sv
// Passive checker for the one-hot lamp bus. It verifies the GREEN -> YELLOW ->
// RED -> GREEN order and how long each phase is held. It reports lock status,
// error pulses with a cause code, and a count of completed RED->GREEN cycles.
module lamp_seq_monitor #(
  parameter int unsigned MIN_DWELL  = 1,
  parameter int unsigned MAX_DWELL  = 1,
  parameter int unsigned LOCK_TRANS = 3,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned DW_W       = 8
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [2:0]       light,
  output logic [2:0]       phase,
  output logic             locked,
  output logic             err_valid,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int unsigned TR_W = (LOCK_TRANS < 2) ? 1 : $clog2(LOCK_TRANS + 1);

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] YELLOW = 3'b001;

  localparam logic [1:0] ERR_ILLEGAL = 2'd0;
  localparam logic [1:0] ERR_SEQ     = 2'd1;
  localparam logic [1:0] ERR_SHORT   = 2'd2;
  localparam logic [1:0] ERR_STUCK   = 2'd3;

  typedef enum logic {HUNT, TRACK} state_t;

  state_t            state, state_nxt;
  logic [2:0]        phase_nxt;
  logic              locked_nxt;
  logic              err_valid_nxt;
  logic [1:0]        err_code_nxt;
  logic [CNT_W-1:0]  cycle_count_nxt;
  logic [DW_W-1:0]   dwell, dwell_nxt, dwell_inc;
  logic [TR_W-1:0]   trans, trans_nxt, trans_inc;
  logic              legal;
  logic [2:0]        succ;
  logic              err_hit;
  logic [1:0]        err_sel;

  // Expected successor of an accepted phase
  function automatic logic [2:0] next_lamp(input logic [2:0] p);
    case (p)
      GREEN:   return YELLOW;
      YELLOW:  return RED;
      RED:     return GREEN;
      default: return 3'b000;
    endcase
  endfunction

  // State and output registers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      phase       <= 3'b000;
      locked      <= 1'b0;
      err_valid   <= 1'b0;
      err_code    <= ERR_ILLEGAL;
      cycle_count <= '0;
      dwell       <= '0;
      trans       <= '0;
    end else begin
      state       <= state_nxt;
      phase       <= phase_nxt;
      locked      <= locked_nxt;
      err_valid   <= err_valid_nxt;
      err_code    <= err_code_nxt;
      cycle_count <= cycle_count_nxt;
      dwell       <= dwell_nxt;
      trans       <= trans_nxt;
    end
  end

  // Next-state evaluation of the sampled lamp code in priority order
  always_comb begin
    state_nxt       = state;
    phase_nxt       = phase;
    locked_nxt      = locked;
    err_valid_nxt   = 1'b0;
    err_code_nxt    = err_code;
    cycle_count_nxt = cycle_count;
    dwell_nxt       = dwell;
    trans_nxt       = trans;
    err_hit         = 1'b0;
    err_sel         = ERR_ILLEGAL;

    legal     = (light == RED) || (light == GREEN) || (light == YELLOW);
    succ      = next_lamp(phase);
    dwell_inc = (dwell == '1) ? dwell : dwell + DW_W'(1);
    trans_inc = (trans >= TR_W'(LOCK_TRANS)) ? trans : trans + TR_W'(1);

    case (state)
      HUNT: begin
        if (legal) begin
          state_nxt = TRACK;
          phase_nxt = light;
          dwell_nxt = DW_W'(1);
          trans_nxt = '0;
        end
      end
      TRACK: begin
        if (!legal) begin
          err_hit = 1'b1;
          err_sel = ERR_ILLEGAL;
        end else if (light == phase) begin
          dwell_nxt = dwell_inc;
          if (dwell_inc > DW_W'(MAX_DWELL)) begin
            err_hit = 1'b1;
            err_sel = ERR_STUCK;
          end
        end else if (light != succ) begin
          err_hit = 1'b1;
          err_sel = ERR_SEQ;
        end else if (dwell < DW_W'(MIN_DWELL)) begin
          err_hit = 1'b1;
          err_sel = ERR_SHORT;
        end else begin
          phase_nxt = light;
          dwell_nxt = DW_W'(1);
          trans_nxt = trans_inc;
          if (trans_inc == TR_W'(LOCK_TRANS)) begin
            locked_nxt = 1'b1;
          end
          // Only cycles completed while already locked are counted
          if ((phase == RED) && locked) begin
            cycle_count_nxt = cycle_count + CNT_W'(1);
          end
        end
      end
      default: state_nxt = HUNT;
    endcase

    // Any violation drops lock and restarts acquisition; the count is kept
    if (err_hit) begin
      err_valid_nxt = 1'b1;
      err_code_nxt  = err_sel;
      locked_nxt    = 1'b0;
      trans_nxt     = '0;
      state_nxt     = HUNT;
      phase_nxt     = 3'b000;
      dwell_nxt     = '0;
    end
  end

endmodule

// File: tb/tb_lamp_seq_monitor.sv
// Scoreboard bench for lamp_seq_monitor: stimulus pushes hand-computed
// expectations, a monitor pops and compares one entry per sampled edge.
module tb_lamp_seq_monitor;

  localparam logic [2:0] LR = 3'b100;
  localparam logic [2:0] LG = 3'b010;
  localparam logic [2:0] LY = 3'b001;
  localparam logic [2:0] LZ = 3'b000;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] light0 = 3'b000;
  logic [2:0] light1 = 3'b000;

  logic [2:0] phase0, phase1;
  logic       locked0, locked1;
  logic       ev0, ev1;
  logic [1:0] code0, code1;
  logic [7:0] cnt0, cnt1;

  typedef struct {
    int         sel;
    string      name;
    logic [2:0] ph;
    logic       lk;
    logic       ev;
    logic [1:0] code;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  event chk_ev;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;

  lamp_seq_monitor u_dut0 (
    .clock(clock), .rst_n(rst_n), .light(light0),
    .phase(phase0), .locked(locked0), .err_valid(ev0),
    .err_code(code0), .cycle_count(cnt0)
  );

  lamp_seq_monitor #(.MIN_DWELL(2), .MAX_DWELL(3)) u_dut1 (
    .clock(clock), .rst_n(rst_n), .light(light1),
    .phase(phase1), .locked(locked1), .err_valid(ev1),
    .err_code(code1), .cycle_count(cnt1)
  );

  // Drive one sample on the next falling edge and queue its expected result
  task automatic step(input int sel, input logic [2:0] l, input string name,
                      input logic [2:0] ph, input logic lk, input logic ev,
                      input logic [1:0] code, input logic [7:0] cnt);
    exp_t e;
    @(negedge clock);
    if (sel == 0) begin
      light0 = l;
      light1 = LZ;
    end else begin
      light1 = l;
      light0 = LZ;
    end
    e.sel = sel; e.name = name; e.ph = ph; e.lk = lk;
    e.ev = ev; e.code = code; e.cnt = cnt;
    sb.push_back(e);
  endtask

  // Queue an expectation checked between clock edges
  task automatic now_check(input int sel, input string name);
    exp_t e;
    e.sel = sel; e.name = name; e.ph = LZ; e.lk = 1'b0;
    e.ev = 1'b0; e.code = 2'd0; e.cnt = 8'd0;
    sb.push_back(e);
    ->chk_ev;
  endtask

  // Monitor: compare one queued expectation after each sampling point
  initial begin
    exp_t       e;
    logic [2:0] ph;
    logic       lk, ev;
    logic [1:0] code;
    logic [7:0] cnt;
    forever begin
      @(posedge clock or chk_ev);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.sel == 0) begin
          ph = phase0; lk = locked0; ev = ev0; code = code0; cnt = cnt0;
        end else begin
          ph = phase1; lk = locked1; ev = ev1; code = code1; cnt = cnt1;
        end
        vectors++;
        if (ph !== e.ph || lk !== e.lk || ev !== e.ev || code !== e.code || cnt !== e.cnt) begin
          miscompares++;
          $display("FAIL %s (dut%0d): got phase=%b locked=%b err_valid=%b err_code=%0d count=%0d, want phase=%b locked=%b err_valid=%b err_code=%0d count=%0d",
                   e.name, e.sel, ph, lk, ev, code, cnt, e.ph, e.lk, e.ev, e.code, e.cnt);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    #2 now_check(0, "reset0");
    #2 now_check(1, "reset1");
    #4 rst_n = 1'b1;

    // Clean acquisition and first counted cycle
    step(0, LG, "acq_g",  LG, 0, 0, 0, 0);
    step(0, LY, "acq_y",  LY, 0, 0, 0, 0);
    step(0, LR, "acq_r",  LR, 0, 0, 0, 0);
    step(0, LG, "lock_g", LG, 1, 0, 0, 0);
    step(0, LY, "lk_y",   LY, 1, 0, 0, 0);
    step(0, LR, "lk_r",   LR, 1, 0, 0, 0);
    step(0, LG, "cnt1_g", LG, 1, 0, 0, 1);

    // Green held twice with MAX_DWELL=1 -> stuck
    step(0, LG, "stuck",  LZ, 0, 1, 3, 1);
    step(0, LG, "re_g",   LG, 0, 0, 3, 1);
    step(0, LY, "re_y",   LY, 0, 0, 3, 1);
    step(0, LR, "re_r",   LR, 0, 0, 3, 1);
    step(0, LG, "re_lock",LG, 1, 0, 3, 1);

    // Out-of-order green after yellow; offending sample not reused
    step(0, LY, "seq_y",  LY, 1, 0, 3, 1);
    step(0, LG, "seq_err",LZ, 0, 1, 1, 1);
    step(0, LG, "seq_acq",LG, 0, 0, 1, 1);

    // Illegal code in TRACK, then illegal codes ignored in HUNT
    step(0, 3'b011, "illegal",  LZ, 0, 1, 0, 1);
    step(0, 3'b000, "hunt_000", LZ, 0, 0, 0, 1);
    step(0, 3'b111, "hunt_111", LZ, 0, 0, 0, 1);

    // Build up cycle_count to 5
    step(0, LG, "b_g",    LG, 0, 0, 0, 1);
    step(0, LY, "b_y",    LY, 0, 0, 0, 1);
    step(0, LR, "b_r",    LR, 0, 0, 0, 1);
    step(0, LG, "b_lock", LG, 1, 0, 0, 1);
    for (int k = 2; k <= 5; k++) begin
      step(0, LY, "b_cy", LY, 1, 0, 0, 8'(k - 1));
      step(0, LR, "b_cr", LR, 1, 0, 0, 8'(k - 1));
      step(0, LG, "b_cg", LG, 1, 0, 0, 8'(k));
    end

    // Asynchronous reset between edges
    @(negedge clock);
    #2 rst_n = 1'b0;
    now_check(0, "mid_reset");
    #4 rst_n = 1'b1;

    step(0, LG, "r_g",    LG, 0, 0, 0, 0);
    step(0, LY, "r_y",    LY, 0, 0, 0, 0);
    step(0, LR, "r_r",    LR, 0, 0, 0, 0);
    step(0, LG, "r_lock", LG, 1, 0, 0, 0);
    step(0, LY, "r_y2",   LY, 1, 0, 0, 0);
    step(0, LR, "r_r2",   LR, 1, 0, 0, 0);
    step(0, LG, "r_cnt1", LG, 1, 0, 0, 1);

    // MIN_DWELL=2, MAX_DWELL=3: yellow held one cycle -> short
    step(1, LG, "d_g1",   LG, 0, 0, 0, 0);
    step(1, LG, "d_g2",   LG, 0, 0, 0, 0);
    step(1, LY, "d_y1",   LY, 0, 0, 0, 0);
    step(1, LR, "short",  LZ, 0, 1, 2, 0);

    // Red held 3 legal, 4th is stuck
    step(1, LG, "s_g1",   LG, 0, 0, 2, 0);
    step(1, LG, "s_g2",   LG, 0, 0, 2, 0);
    step(1, LY, "s_y1",   LY, 0, 0, 2, 0);
    step(1, LY, "s_y2",   LY, 0, 0, 2, 0);
    step(1, LR, "s_r1",   LR, 0, 0, 2, 0);
    step(1, LR, "s_r2",   LR, 0, 0, 2, 0);
    step(1, LR, "s_r3",   LR, 0, 0, 2, 0);
    step(1, LR, "stuck4", LZ, 0, 1, 3, 0);
    step(1, LG, "s_acq",  LG, 0, 0, 3, 0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
